psc_trigger_frame_receiver: RTL and testbench

//  Downstream stage of the PSC trigger transmitter: deserialises the psc_output line (idle-high,
//  10-bit symbols), recovers bytes, groups them into fixed-length frames and checks the trailing CRC-8.

---
 rtl/psc_trigger_pkg.sv | 15 +
 rtl/psc_crc8_byte_update.sv | 22 ++
 rtl/psc_trigger_frame_receiver.sv | 138 +++++++++++++
 tb/tb_psc_trigger_frame_receiver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/psc_trigger_pkg.sv
// rtl/psc_trigger_pkg.sv - shared constants and rx FSM state type for the PSC trigger link
package psc_trigger_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT    = 8'h07;
    localparam int         SYMBOL_BITS          = 10;
    localparam int         CLKS_PER_BIT_DEFAULT = 5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/psc_crc8_byte_update.sv
// rtl/psc_crc8_byte_update.sv - combinational CRC-8 update by one byte, MSB first
module psc_crc8_byte_update
    import psc_trigger_pkg::*;
#(
    parameter logic [7:0] CRC_POLY = CRC8_POLY_DEFAULT
) (
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    logic [7:0] acc;

    always_comb begin
        acc = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            acc = acc[7] ? ({acc[6:0], 1'b0} ^ CRC_POLY) : {acc[6:0], 1'b0};
        end
        crc_next = acc;
    end

endmodule

// File: rtl/psc_trigger_frame_receiver.sv
// rtl/psc_trigger_frame_receiver.sv - deserialises psc_output symbols into CRC-8 checked frames
module psc_trigger_frame_receiver
    import psc_trigger_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int         FRAME_BYTES  = 4,
    parameter logic [7:0] CRC_POLY     = CRC8_POLY_DEFAULT,
    parameter int         IDLE_BITS    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_in,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        framing_error,
    output logic [15:0] frame_count
);

    localparam int IDX_W      = $clog2(FRAME_BYTES);
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [7:0]        HALF_BIT   = 8'(CLKS_PER_BIT / 2);
    localparam logic [7:0]        FULL_BIT   = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_LIMIT - 1);

    rx_state_e         state_q, state_d;
    logic              sync_q1, sync_q2, rx_prev;
    logic [7:0]        bit_cnt_q;
    logic [2:0]        data_cnt_q;
    logic [7:0]        shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        crc_q;
    logic [7:0]        crc_next;
    logic [IDLE_W-1:0] idle_cnt_q;

    logic rx, fall, tick;
    logic load_half, reload_full, shift_en, byte_accept, frame_err, idle_abort;

    assign rx   = sync_q2;
    assign fall = rx_prev & ~rx;
    assign tick = (bit_cnt_q == 8'd0);

    psc_crc8_byte_update #(.CRC_POLY(CRC_POLY)) u_crc (
        .crc      (crc_q),
        .data     (shift_q),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (tick) state_d = rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && data_cnt_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (tick) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        load_half   = (state_q == RX_IDLE) && fall;
        reload_full = tick && (((state_q == RX_START) && !rx) || (state_q == RX_DATA));
        shift_en    = tick && (state_q == RX_DATA);
        byte_accept = tick && (state_q == RX_STOP) && rx;
        frame_err   = tick && (state_q == RX_STOP) && !rx;
        idle_abort  = (state_q == RX_IDLE) && rx && (idx_q != '0) && (idle_cnt_q == IDLE_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q1       <= 1'b1;
            sync_q2       <= 1'b1;
            rx_prev       <= 1'b1;
            bit_cnt_q     <= 8'd0;
            data_cnt_q    <= 3'd0;
            shift_q       <= 8'd0;
            idx_q         <= '0;
            crc_q         <= 8'd0;
            idle_cnt_q    <= '0;
            byte_data     <= 8'd0;
            byte_valid    <= 1'b0;
            frame_done    <= 1'b0;
            crc_ok        <= 1'b0;
            framing_error <= 1'b0;
            frame_count   <= 16'd0;
        end else begin
            sync_q1       <= serial_in;
            sync_q2       <= sync_q1;
            rx_prev       <= rx;
            byte_valid    <= 1'b0;
            frame_done    <= 1'b0;
            framing_error <= 1'b0;

            if (load_half)            bit_cnt_q <= HALF_BIT;
            else if (reload_full)     bit_cnt_q <= FULL_BIT;
            else if (bit_cnt_q != 0)  bit_cnt_q <= bit_cnt_q - 8'd1;

            if (state_q == RX_START) data_cnt_q <= 3'd0;
            if (shift_en) begin
                shift_q    <= {shift_q[6:0], rx};
                data_cnt_q <= data_cnt_q + 3'd1;
            end

            // The last byte of a frame is the transmitted CRC, never folded into the running CRC.
            if (byte_accept) begin
                byte_data  <= shift_q;
                byte_valid <= 1'b1;
                if (idx_q == LAST_IDX) begin
                    frame_done <= 1'b1;
                    crc_ok     <= (shift_q == crc_q);
                    if (shift_q == crc_q) frame_count <= frame_count + 16'd1;
                    idx_q      <= '0;
                    crc_q      <= 8'd0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                    crc_q <= crc_next;
                end
            end else if (frame_err || idle_abort) begin
                framing_error <= frame_err;
                idx_q         <= '0;
                crc_q         <= 8'd0;
            end

            if (state_q != RX_IDLE || !rx || idx_q == '0 || idle_abort) idle_cnt_q <= '0;
            else                                                         idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_psc_trigger_frame_receiver.sv
// tb/tb_psc_trigger_frame_receiver.sv - scoreboard bench for psc_trigger_frame_receiver
module tb_psc_trigger_frame_receiver;

    localparam int         C    = 5;
    localparam int         FB   = 4;
    localparam logic [7:0] POLY = 8'h07;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        serial_in = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid, frame_done, crc_ok, framing_error;
    logic [15:0] frame_count;

    psc_trigger_frame_receiver #(
        .CLKS_PER_BIT(C), .FRAME_BYTES(FB), .CRC_POLY(POLY), .IDLE_BITS(12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .frame_done    (frame_done),
        .crc_ok        (crc_ok),
        .framing_error (framing_error),
        .frame_count   (frame_count)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        ferr;
        logic        fdone;
        logic        ok;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  frame_q[$];
    logic [15:0] model_count = 16'd0;
    int          checks = 0;
    int          passed = 0;
    int          evt_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // CRC as the remainder of polynomial long division of (message * x^8) by x^8 + POLY.
    function automatic logic [7:0] crc_div(input logic [7:0] msg[$]);
        logic       bits[$];
        logic [8:0] p;
        logic [7:0] r;
        p = {1'b1, POLY};
        foreach (msg[k]) for (int i = 7; i >= 0; i--) bits.push_back(msg[k][i]);
        repeat (8) bits.push_back(1'b0);
        for (int i = 0; i + 8 < bits.size(); i++)
            if (bits[i]) for (int j = 0; j <= 8; j++) bits[i+j] = bits[i+j] ^ p[8-j];
        for (int j = 0; j < 8; j++) r[7-j] = bits[bits.size()-8+j];
        return r;
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        exp_t       e;
        logic [7:0] body[$];
        e = '{data: b, ferr: !stop_ok, fdone: 1'b0, ok: 1'b0, cnt: 16'd0};
        if (!stop_ok) begin
            frame_q.delete();
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == FB) begin
                for (int i = 0; i < FB - 1; i++) body.push_back(frame_q[i]);
                e.fdone = 1'b1;
                e.ok    = (crc_div(body) == b);
                if (e.ok) model_count = model_count + 16'd1;
                e.cnt   = model_count;
                frame_q.delete();
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        if (n >= 14) frame_q.delete();
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        model_byte(b, stop_ok);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) begin drive_bit(1'b1); drive_bit(1'b1); end
    endtask

    task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] crc_flip, input logic gaps);
        logic [7:0] c;
        c = crc_div(pl) ^ crc_flip;
        foreach (pl[k]) begin
            send_byte(pl[k], 1'b1);
            if (gaps) idle_bits($urandom_range(0, 2));
        end
        send_byte(c, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_data"}, byte_data, 0);
        check({tag, "_byte_valid"}, byte_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_crc_ok"}, crc_ok, 0);
        check({tag, "_framing_error"}, framing_error, 0);
        check({tag, "_frame_count"}, frame_count, 0);
    endtask

    always @(negedge clk) begin
        if (reset && (byte_valid || framing_error || frame_done)) begin
            exp_t e;
            evt_cnt++;
            check("strobe_exclusive", byte_valid & framing_error, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("framing_error", framing_error, e.ferr);
                check("byte_valid", byte_valid, !e.ferr);
                check("frame_done", frame_done, e.fdone);
                if (!e.ferr) check("byte_data", byte_data, e.data);
                if (e.fdone) begin
                    check("crc_ok", crc_ok, e.ok);
                    check("frame_count", frame_count, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] b1;
        int         ev0, wait_cyc;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        idle_bits(3);

        pl = '{8'hA5, 8'h01, 8'h3C};
        send_frame(pl, 8'h00, 1'b0);
        idle_bits(2);
        send_frame(pl, 8'h01, 1'b0);
        idle_bits(2);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_frame(pl, 8'h00, 1'b0);
        idle_bits(2);

        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        idle_bits(14);
        send_frame(pl, 8'h00, 1'b0);
        idle_bits(2);

        ev0 = evt_cnt;
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(4);
        check("glitch_no_strobe", evt_cnt - ev0, 0);
        check("glitch_fsm_idle", dut.state_q, 0);

        send_byte(8'h11, 1'b1);
        b1 = 8'h5A;
        drive_bit(1'b0);
        for (int i = 7; i >= 4; i--) drive_bit(b1[i]);
        serial_in = b1[3];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        serial_in   = 1'b1;
        frame_q.delete();
        model_count = 16'd0;
        reset       = 1'b1;
        idle_bits(14);
        send_frame(pl, 8'h00, 1'b0);
        idle_bits(2);

        for (int f = 0; f < 20; f++) begin
            pl.delete();
            for (int k = 0; k < FB - 1; k++) pl.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0) begin
                send_byte(pl[0], 1'b1);
                send_byte(pl[1], 1'b0);
            end else if ($urandom_range(0, 9) == 0) begin
                send_byte(pl[0], 1'b1);
                idle_bits($urandom_range(14, 16));
            end else begin
                send_frame(pl, ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, 1'b1);
            end
            idle_bits($urandom_range(0, 2));
        end

        idle_bits(14);
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        model_count = 16'hFFFF;
        @(negedge clk);
        check("preload_count", frame_count, 16'hFFFF);
        pl = '{8'h12, 8'h34, 8'h56};
        send_frame(pl, 8'h00, 1'b0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
        end
        repeat (4 * C) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_frame_count", frame_count, model_count);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
